l1d_mem_bridge: RTL and testbench
=================================

# l1d_mem_bridge

Memory-side responder for the L1 data cache's request interface (`D_req`/`D_write`/`D_addr`/`D_in`/`D_type` in, `D_out`/`D_wait` out). It converts each cache request into an AXI4 master transaction:
- a 4-beat INCR line refill for a cacheable read;
- a single-beat read for an uncacheable read;
- a single-beat write for any write.

It sits between `L1C_data` and the AXI interconnect, inside the CPU wrapper.

## Interface
- `UNCACHED_HI`, default 16'h1000: address bits [31:16] that mark a request as uncacheable.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `D_req` in 1: read request, held high until the last beat is delivered.
- `D_write` in 1: write request, held high until acknowledged.
- `D_addr` in 32: request address (line-aligned for cacheable reads).
- `D_in` in 32: write data.
- `D_type` in 4: active-low byte write enable (4'hf = no byte written).
- `D_out` out 32: read beat data.
- `D_wait` out 1: low for exactly one cycle per delivered read beat or write acknowledge; high otherwise.
- `bus_err` out 1: sticky flag, set by any non-OKAY RRESP or BRESP.
- `ARADDR`/`ARLEN`/`ARSIZE`/`ARBURST`/`ARVALID` out 32/4/3/2/1; `ARREADY` in 1.
- `RDATA`/`RRESP`/`RLAST`/`RVALID` in 32/2/1/1; `RREADY` out 1.
- `AWADDR`/`AWLEN`/`AWSIZE`/`AWBURST`/`AWVALID` out 32/4/3/2/1; `AWREADY` in 1.
- `WDATA`/`WSTRB`/`WLAST`/`WVALID` out 32/4/1/1; `WREADY` in 1.
- `BRESP`/`BVALID` in 2/1; `BREADY` out 1.

## Operation
States: `IDLE`, `RD_ADDR`, `RD_DATA`, `WR_REQ`, `WR_RESP`, `ACK`.

- **IDLE**
  - `D_write` high: latch `D_addr`, `D_in`, `D_type`; go to `WR_REQ`. `D_write` wins if `D_req` is also high.
  - Else `D_req` high: latch `D_addr`; go to `RD_ADDR`.
- **RD_ADDR**
  - Drive `ARVALID`=1 and `ARADDR` = latched address.
  - `ARSIZE`=3'b010, `ARBURST`=INCR.
  - `ARLEN`=3 if cacheable, 0 if uncacheable (`addr[31:16]==UNCACHED_HI`).
  - On `ARREADY`, go to `RD_DATA`.
- **RD_DATA**
  - `RREADY`=1.
  - On each R handshake, register `RDATA` into `D_out` and pulse `D_wait` low for the next cycle.
  - On the handshake with `RLAST`=1, go to `ACK`. That cycle is the pulse for the final beat.
  - Beats are delivered in address order: offsets 0, 1, 2, 3.
- **WR_REQ**
  - Assert `AWVALID` and `WVALID` together. Each is dropped independently after its own handshake; two done flags track completion.
  - `AWLEN`=0, `WLAST`=1, `WSTRB`=~`D_type`, `WDATA` = latched data.
  - When both AW and W handshakes are done, go to `WR_RESP`.
- **WR_RESP**
  - `BREADY`=1.
  - On `BVALID`, go to `ACK`.
- **ACK**
  - `D_wait`=0 for this one cycle; go to `IDLE`.
  - The cache drops `D_req`/`D_write` in this cycle, so `IDLE` never re-triggers on a finished request.
- **Errors:** `RRESP`/`BRESP` != 2'b00 sets `bus_err`. The beat or acknowledge is still delivered normally, with no retry.
- **Request drop:** if `D_req` or `D_write` drops mid-transaction, the AXI transaction still completes and the acknowledge pulses are still issued.

## Timing
- **Reset values:**
  - State `IDLE`.
  - `D_wait`=1, `D_out`=0, `bus_err`=0.
  - All VALID/READY outputs 0.
  - Address, data, strobe and length outputs 0.
- **Registered outputs:** `D_out` and `D_wait` are registered. A beat handshake at edge N gives `D_out` valid and `D_wait`=0 during cycle N+1.
- **Latency:**
  - Read: request to first `D_wait` low is at least 3 cycles with zero-wait AXI (IDLE → RD_ADDR → RD_DATA → pulse).
  - Write: acknowledge at the earliest 3 cycles after `D_write` rises.
- **Held outputs:** AXI outputs are held stable while VALID is high and READY is low.
- **Back-to-back beats:** RVALID high on consecutive cycles gives consecutive `D_wait` low cycles, one per beat. The cache counts every low cycle as a beat.
- **Mid-operation reset:** all outputs return to reset values immediately; any outstanding AXI transaction is abandoned.

## Structure
- Shared package `mem_bridge_pkg`:
  - state enum `bridge_state_e`;
  - `AXI_RESP_OKAY`, `AXI_BURST_INCR`, `AXI_SIZE_WORD`;
  - `LINE_BEATS`=4.
- No sub-module. One FSM, request latch registers, AW/W done flags, `bus_err` flag.

## Test plan
1. **Cacheable read:** `D_req`, `D_addr`=0x0000_1230; zero-wait memory returns 0xA0..0xA3 → `ARADDR`=0x1230, `ARLEN`=3; `D_wait` low on 4 consecutive cycles with `D_out`=0xA0, 0xA1, 0xA2, 0xA3; then `IDLE`.
2. **Uncacheable read:** `D_addr`=0x1000_0004; RDATA=0x55 after 5-cycle `ARREADY` stall → `ARLEN`=0, `ARADDR` stable during the stall; one `D_wait` low cycle with `D_out`=0x55.
3. **Partial write:** `D_write`, `D_addr`=0x8, `D_in`=0xDEADBEEF, `D_type`=4'b1100 → `WSTRB`=4'b0011, `AWLEN`=0; `D_wait` low one cycle after `BVALID`.
4. **AW/W skew:** `AWREADY` 3 cycles before `WREADY` → `AWVALID` drops after its handshake, `WVALID` held until `WREADY`; exactly one acknowledge.
5. **Simultaneous requests and error:** `D_req` and `D_write` high together → write issued first; then `RRESP`=2'b10 on beat 2 → `bus_err`=1, all 4 beats still delivered.
6. **Reset mid-burst:** `rst` low after beat 1 → `D_wait`=1, `RREADY`=0, state `IDLE`; a new read after release behaves as in scenario 1.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and AXI constants for the L1D memory bridge
package mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      ACK     = 3'd5
   } bridge_state_e;

   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam int         LINE_BEATS     = 4;

endpackage

// File: rtl/l1d_mem_bridge.sv
// rtl/l1d_mem_bridge.sv - L1 data cache request port to AXI4 master bridge
module l1d_mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter logic [15:0] UNCACHED_HI = 16'h1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        D_req,
   input  logic        D_write,
   input  logic [31:0] D_addr,
   input  logic [31:0] D_in,
   input  logic [3:0]  D_type,
   output logic [31:0] D_out,
   output logic        D_wait,
   output logic        bus_err,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   bridge_state_e state, state_nxt;
   logic [31:0]   addr_q;
   logic [31:0]   data_q;
   logic [3:0]    type_q;
   logic          aw_done, w_done;
   logic          aw_fin, w_fin;
   logic          uncached;
   logic          r_hs, b_hs;

   assign uncached = (addr_q[31:16] == UNCACHED_HI);
   assign aw_fin   = aw_done | (AWVALID & AWREADY);
   assign w_fin    = w_done  | (WVALID & WREADY);
   assign r_hs     = RVALID & RREADY;
   assign b_hs     = BVALID & BREADY;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (D_write)    state_nxt = WR_REQ;
            else if (D_req) state_nxt = RD_ADDR;
         end
         RD_ADDR: if (ARREADY)      state_nxt = RD_DATA;
         RD_DATA: if (r_hs && RLAST) state_nxt = ACK;
         WR_REQ:  if (aw_fin && w_fin) state_nxt = WR_RESP;
         WR_RESP: if (BVALID)       state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ARVALID = 1'b0;
      ARLEN   = 4'd0;
      RREADY  = 1'b0;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      WLAST   = 1'b0;
      BREADY  = 1'b0;
      case (state)
         RD_ADDR: begin
            ARVALID = 1'b1;
            ARLEN   = uncached ? 4'd0 : 4'(LINE_BEATS - 1);
         end
         RD_DATA: RREADY = 1'b1;
         WR_REQ: begin
            AWVALID = ~aw_done;
            WVALID  = ~w_done;
            WLAST   = 1'b1;
         end
         WR_RESP: BREADY = 1'b1;
         default: ;
      endcase
   end

   assign ARADDR  = addr_q;
   assign ARSIZE  = AXI_SIZE_WORD;
   assign ARBURST = AXI_BURST_INCR;
   assign AWADDR  = addr_q;
   assign AWLEN   = 4'd0;
   assign AWSIZE  = AXI_SIZE_WORD;
   assign AWBURST = AXI_BURST_INCR;
   assign WDATA   = data_q;
   assign WSTRB   = ~type_q;

   // D_wait is registered, so the ACK cycle carries the pulse for the final read beat
   // or for the write response accepted one edge earlier.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         type_q  <= 4'hf;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         D_out   <= 32'd0;
         D_wait  <= 1'b1;
         bus_err <= 1'b0;
      end else begin
         D_wait <= ~(r_hs | b_hs);
         if (state == IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (D_write) begin
               addr_q <= D_addr;
               data_q <= D_in;
               type_q <= D_type;
            end else if (D_req) begin
               addr_q <= D_addr;
            end
         end
         if (state == WR_REQ) begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
         end
         if (r_hs) begin
            D_out <= RDATA;
            if (RRESP != AXI_RESP_OKAY) bus_err <= 1'b1;
         end
         if (b_hs && BRESP != AXI_RESP_OKAY) bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l1d_mem_bridge.sv
// tb/tb_l1d_mem_bridge.sv - scoreboard bench for l1d_mem_bridge with an AXI memory model
module tb_l1d_mem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        D_req, D_write;
   logic [31:0] D_addr, D_in;
   logic [3:0]  D_type;
   logic [31:0] D_out;
   logic        D_wait, bus_err;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST, RVALID, RREADY;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST, WVALID, WREADY;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;

   always #5 clk = ~clk;

   l1d_mem_bridge #(.UNCACHED_HI(16'h1000)) dut (
      .clk(clk), .rst(rst),
      .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in), .D_type(D_type),
      .D_out(D_out), .D_wait(D_wait), .bus_err(bus_err),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   typedef struct {bit is_wr; logic [31:0] data;} exp_t;
   typedef struct {logic [31:0] addr; logic [3:0] len;} ar_t;
   typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} aw_t;

   exp_t exp_q[$];
   ar_t  ar_exp[$];
   aw_t  aw_exp[$];

   int cmp_n = 0;
   int fail_n = 0;

   logic [31:0] smem [logic [31:0]];
   logic [31:0] mmem [logic [31:0]];

   bit  rand_mode = 0;
   int  ar_delay = 0, aw_delay = 0, w_delay = 0;
   int  err_beat = -1;
   bit  b_err = 0;
   bit  exp_err = 0;
   int  cyc = 0, first_low = -1, last_low = -1;
   int  ar_stall_seen = 0;
   longint ar_hs_t = 0, aw_hs_t = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         fail_n++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      cmp_n++;
      fail_n++;
      $display("FAIL %s: got event expected none", name);
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   function automatic logic [31:0] s_rd(input logic [31:0] a);
      return smem.exists(a) ? smem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] a);
      return mmem.exists(a) ? mmem[a] : init_word(a);
   endfunction

   // Reference write: D_type is active-low per byte.
   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
      logic [31:0] w;
      w = m_rd(a);
      for (int b = 0; b < 4; b++)
         if (!t[b]) w[8*b +: 8] = d[8*b +: 8];
      mmem[a] = w;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      smem[a] = v;
      mmem[a] = v;
   endtask

   function automatic bit go();
      return rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
   endfunction

   // Scoreboard monitor: every D_wait low cycle consumes one expected pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst && !D_wait) begin
            if (first_low < 0) first_low = cyc;
            last_low = cyc;
            if (exp_q.size() == 0) flag_fail("unexpected_pulse");
            else begin
               e = exp_q.pop_front();
               if (!e.is_wr) check("d_out", D_out, e.data);
            end
         end
      end
   end

   // AXI slave memory; decisions taken at negedge apply to the following posedge.
   initial begin
      logic [31:0] r_addr, ar_hold, aw_hold, w_hold, aw_addr_s, w_data_s;
      logic [3:0]  w_strb_s;
      int r_len, r_beat, ar_cnt, aw_cnt, w_cnt;
      bit r_act, r_hs_prev, ar_pend, aw_pend, w_pend, aw_got, w_got, b_act;
      ar_t r;
      logic [31:0] wv;
      r_act = 0; r_hs_prev = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
      aw_got = 0; w_got = 0; b_act = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      r_len = 0; r_beat = 0; r_addr = 0; ar_hold = 0; aw_hold = 0; w_hold = 0;
      aw_addr_s = 0; w_data_s = 0; w_strb_s = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
            r_act = 0; r_hs_prev = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
            aw_got = 0; w_got = 0; b_act = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
         end else begin
            if (r_act) begin
               if (!RVALID || r_hs_prev) RVALID = go();
               RDATA = s_rd(r_addr + 32'(4 * r_beat));
               RRESP = (r_beat == err_beat) ? 2'b10 : 2'b00;
               RLAST = (r_beat == r_len);
               r_hs_prev = RVALID && RREADY;
               if (r_hs_prev) begin
                  r_beat++;
                  if (r_beat > r_len) r_act = 0;
               end
            end else begin
               RVALID = 0; RLAST = 0; r_hs_prev = 0;
            end

            if (ARVALID) begin
               if (ar_pend) check("araddr_hold", ARADDR, ar_hold);
               ARREADY = rand_mode ? ($urandom_range(0, 2) == 0) : (ar_cnt >= ar_delay);
               if (ARREADY) begin
                  ar_stall_seen = ar_cnt;
                  ar_hs_t = $time;
                  if (ar_exp.size() == 0) flag_fail("ar_unexpected");
                  else begin
                     r = ar_exp.pop_front();
                     check("araddr", ARADDR, r.addr);
                     check("arlen", ARLEN, r.len);
                     check("arsize_burst", {ARSIZE, ARBURST}, {3'b010, 2'b01});
                  end
                  r_act = 1; r_addr = ARADDR; r_len = int'(ARLEN); r_beat = 0;
                  ar_cnt = 0; ar_pend = 0;
               end else begin
                  ar_cnt++; ar_pend = 1; ar_hold = ARADDR;
               end
            end else begin
               ARREADY = 0;
               if (ar_pend) flag_fail("arvalid_dropped");
               ar_pend = 0;
            end

            if (b_act) begin
               if (!BVALID) BVALID = go();
               BRESP = b_err ? 2'b10 : 2'b00;
               if (BVALID && BREADY) begin
                  b_act = 0; aw_got = 0; w_got = 0;
               end
            end else BVALID = 0;

            if (aw_got) begin
               AWREADY = 0;
               if (!b_act || BVALID == 0) check("awvalid_drop", AWVALID, 0);
            end else if (AWVALID) begin
               if (aw_pend) check("awaddr_hold", AWADDR, aw_hold);
               AWREADY = rand_mode ? ($urandom_range(0, 2) == 0) : (aw_cnt >= aw_delay);
               if (AWREADY) begin
                  aw_got = 1; aw_addr_s = AWADDR; aw_hs_t = $time; aw_pend = 0; aw_cnt = 0;
                  if (aw_exp.size() == 0) flag_fail("aw_unexpected");
                  else begin
                     check("awaddr", AWADDR, aw_exp[0].addr);
                     check("awlen_size_burst", {AWLEN, AWSIZE, AWBURST}, {4'd0, 3'b010, 2'b01});
                  end
               end else begin
                  aw_cnt++; aw_pend = 1; aw_hold = AWADDR;
               end
            end else AWREADY = 0;

            if (w_got) begin
               WREADY = 0;
               if (!b_act || BVALID == 0) check("wvalid_drop", WVALID, 0);
            end else if (WVALID) begin
               if (w_pend) check("wdata_hold", WDATA, w_hold);
               WREADY = rand_mode ? ($urandom_range(0, 2) == 0) : (w_cnt >= w_delay);
               if (WREADY) begin
                  w_got = 1; w_data_s = WDATA; w_strb_s = WSTRB; w_pend = 0; w_cnt = 0;
                  if (aw_exp.size() == 0) flag_fail("w_unexpected");
                  else begin
                     check("wdata", WDATA, aw_exp[0].data);
                     check("wstrb", WSTRB, aw_exp[0].strb);
                     check("wlast", WLAST, 1);
                  end
               end else begin
                  w_cnt++; w_pend = 1; w_hold = WDATA;
               end
            end else WREADY = 0;

            if (aw_got && w_got && !b_act && !BVALID) begin
               wv = s_rd(aw_addr_s);
               for (int b = 0; b < 4; b++)
                  if (w_strb_s[b]) wv[8*b +: 8] = w_data_s[8*b +: 8];
               smem[aw_addr_s] = wv;
               if (aw_exp.size() > 0) void'(aw_exp.pop_front());
               b_act = 1;
            end
         end
      end
   end

   task automatic run_req(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] t);
      int n, total, got, budget;
      exp_t e;
      aw_t  w;
      ar_t  r;
      n = 0;
      if (wr) begin
         e.is_wr = 1; e.data = 0; exp_q.push_back(e);
         w.addr = a; w.data = d; w.strb = ~t; aw_exp.push_back(w);
         m_write(a, d, t);
         if (b_err) exp_err = 1;
      end
      if (rd) begin
         n = (a[31:16] == 16'h1000) ? 1 : 4;
         r.addr = a; r.len = 4'(n - 1); ar_exp.push_back(r);
         for (int i = 0; i < n; i++) begin
            e.is_wr = 0; e.data = m_rd(a + 32'(4 * i)); exp_q.push_back(e);
         end
         if (err_beat >= 0 && err_beat < n) exp_err = 1;
      end
      total = (wr ? 1 : 0) + n;
      first_low = -1;
      @(posedge clk); #1;
      D_write = wr; D_req = rd; D_addr = a; D_in = d; D_type = t;
      got = 0; budget = 0;
      while (got < total && budget < 300) begin
         @(negedge clk);
         budget++;
         if (!D_wait) begin
            got++;
            if (wr && got == 1) D_write = 0;
            if (got == total) begin D_req = 0; D_write = 0; end
         end
      end
      if (got < total) begin
         check("req_timeout_pulses", got, total);
         D_req = 0; D_write = 0;
      end
      check("bus_err", bus_err, exp_err);
      err_beat = -1; b_err = 0;
   endtask

   initial begin
      logic [31:0] a, d;
      int budget, kind;
      rst = 0; D_req = 0; D_write = 0; D_addr = 0; D_in = 0; D_type = 4'hf;
      repeat (3) @(negedge clk);
      check("rst_d_wait", D_wait, 1);
      check("rst_d_out", D_out, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
      check("rst_araddr_arlen", {ARADDR, ARLEN}, 0);
      check("rst_aw_w", {AWADDR, WDATA, WSTRB}, 0);
      @(posedge clk); #1 rst = 1;

      // cacheable line refill, zero-wait
      for (int i = 0; i < 4; i++) preload(32'h1230 + 32'(4 * i), 32'hA0 + 32'(i));
      run_req(0, 1, 32'h0000_1230, 0, 4'hf);
      check("refill_consecutive", last_low - first_low, 3);

      // uncacheable read behind a 5-cycle ARREADY stall
      preload(32'h1000_0004, 32'h55);
      ar_delay = 5;
      run_req(0, 1, 32'h1000_0004, 0, 4'hf);
      check("ar_stall_cycles", ar_stall_seen, 5);
      ar_delay = 0;

      // partial write then read the line back
      run_req(1, 0, 32'h8, 32'hDEADBEEF, 4'b1100);
      run_req(0, 1, 32'h0, 0, 4'hf);

      // AW accepted three cycles before W
      w_delay = 3;
      run_req(1, 0, 32'h1000_0010, 32'h1234_5678, 4'b0000);
      w_delay = 0;

      // simultaneous write+read, error on the second read beat
      err_beat = 1;
      run_req(1, 1, 32'h40, 32'hCAFE_F00D, 4'b0000);
      check("write_before_read", ar_hs_t > aw_hs_t, 1);

      // reset in the middle of a refill
      exp_q.push_back('{0, m_rd(32'h1230)});
      ar_exp.push_back('{32'h1230, 4'd3});
      @(posedge clk); #1 D_req = 1; D_addr = 32'h1230;
      budget = 0;
      do begin @(negedge clk); budget++; end while (D_wait && budget < 50);
      check("mid_rst_first_beat", D_wait, 0);
      @(posedge clk); #2 rst = 0; D_req = 0;
      #1;
      check("mid_rst_d_wait", D_wait, 1);
      check("mid_rst_ready_valid", {RREADY, ARVALID}, 0);
      exp_q.delete(); ar_exp.delete(); aw_exp.delete(); exp_err = 0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1;
      run_req(0, 1, 32'h0000_1230, 0, 4'hf);
      check("post_rst_consecutive", last_low - first_low, 3);

      // randomized traffic with stalls and occasional errors
      rand_mode = 1;
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 3);
         d = $urandom;
         if ($urandom_range(0, 1) == 1) a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
         else a = 32'(16 * $urandom_range(0, 15));
         if (kind == 0) begin
            if (a[31:16] != 16'h1000) a = a + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b_err = 1;
            run_req(1, 0, a, d, 4'($urandom_range(0, 15)));
         end else begin
            if ($urandom_range(0, 7) == 0) err_beat = $urandom_range(0, 3);
            run_req(0, 1, a, 0, 4'hf);
         end
      end

      repeat (5) @(negedge clk);
      check("left_exp", exp_q.size(), 0);
      check("left_ar", ar_exp.size(), 0);
      check("left_aw", aw_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule
